// File: rtl/serial_pattern_det_if.sv
// Bus bundle between the serial pattern detector and the logic that drives it.
// The master side drives sample/clear controls; the slave side returns the detector state.
interface serial_pattern_det_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               din;
  logic               clr;
  logic [PAT_LEN-1:0] shreg;
  logic               hit;
  logic [CNT_W-1:0]   hit_cnt;
  logic               cnt_sat;

  modport master (
    output en, din, clr,
    input  shreg, hit, hit_cnt, cnt_sat
  );

  modport slave (
    input  en, din, clr,
    output shreg, hit, hit_cnt, cnt_sat
  );
endinterface

// File: rtl/serial_pattern_det.sv
// Serial pattern detector: shifts in din on enabled cp edges and detects an MSB-first pattern.
// It produces a registered hit pulse, a saturating match count and the recent bit history.
module serial_pattern_det #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b1101),
  parameter int                 CNT_W   = 8,
  parameter bit                 OVERLAP = 1'b1
) (
  input logic                 cp,
  input logic                 rst,
  serial_pattern_det_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic               cnt_sat_q, cnt_sat_d;
  logic [PAT_LEN-1:0] shifted;
  logic               match;

  always_comb begin
    shifted   = {shreg_q[PAT_LEN-2:0], bus.din};
    match     = bus.en && (shifted == PATTERN) && (fill_q >= FILL_ARM);
    shreg_d   = shreg_q;
    fill_d    = fill_q;
    hit_d     = match;
    hit_cnt_d = hit_cnt_q;

    if (bus.en) begin
      shreg_d = shifted;
      // Without overlap, a match re-arms only after a full fresh window of samples.
      if (match && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q < FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    if (bus.clr) begin
      hit_cnt_d = '0;
    end else if (match && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    cnt_sat_d = (hit_cnt_d == {CNT_W{1'b1}});
  end

  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      fill_q    <= '0;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
      cnt_sat_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
      cnt_sat_q <= cnt_sat_d;
    end
  end

  assign bus.shreg   = shreg_q;
  assign bus.hit     = hit_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.cnt_sat = cnt_sat_q;

endmodule

// File: tb/tb_serial_pattern_det.sv
// Directed bench for serial_pattern_det: three instances (overlap, no-overlap, 2-bit counter)
// see the same stimulus and are compared against a hand-computed vector table.
module tb_serial_pattern_det;

  logic cp;
  logic rst;
  int   n_chk;
  int   n_fail;

  serial_pattern_det_if #(.PAT_LEN(4), .CNT_W(8)) if_ov ();
  serial_pattern_det_if #(.PAT_LEN(4), .CNT_W(8)) if_no ();
  serial_pattern_det_if #(.PAT_LEN(4), .CNT_W(2)) if_c2 ();

  serial_pattern_det #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8), .OVERLAP(1'b1)) dut_ov (
    .cp(cp), .rst(rst), .bus(if_ov));
  serial_pattern_det #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8), .OVERLAP(1'b0)) dut_no (
    .cp(cp), .rst(rst), .bus(if_no));
  serial_pattern_det #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(2), .OVERLAP(1'b1)) dut_c2 (
    .cp(cp), .rst(rst), .bus(if_c2));

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct {
    logic       en;
    logic       din;
    logic       clr;
    logic       hit;
    logic [3:0] shreg;
    logic [7:0] cnt;
    logic       hit_no;
    logic [7:0] cnt_no;
    logic [1:0] cnt_c2;
    logic       sat_c2;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic en, logic din, logic clr, logic hit, logic [3:0] shreg,
                              logic [7:0] cnt, logic hit_no, logic [7:0] cnt_no,
                              logic [1:0] cnt_c2, logic sat_c2);
    vec_t v;
    v.en = en; v.din = din; v.clr = clr; v.hit = hit; v.shreg = shreg; v.cnt = cnt;
    v.hit_no = hit_no; v.cnt_no = cnt_no; v.cnt_c2 = cnt_c2; v.sat_c2 = sat_c2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic din, input logic clr);
    if_ov.en = en; if_ov.din = din; if_ov.clr = clr;
    if_no.en = en; if_no.din = din; if_no.clr = clr;
    if_c2.en = en; if_c2.din = din; if_c2.clr = clr;
  endtask

  task automatic cyc();
    @(posedge cp);
    @(negedge cp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ov.shreg"}, 32'(if_ov.shreg), 32'h0);
    chk({tag, ".ov.hit"}, 32'(if_ov.hit), 32'h0);
    chk({tag, ".ov.cnt"}, 32'(if_ov.hit_cnt), 32'h0);
    chk({tag, ".ov.sat"}, 32'(if_ov.cnt_sat), 32'h0);
    chk({tag, ".no.shreg"}, 32'(if_no.shreg), 32'h0);
    chk({tag, ".c2.cnt"}, 32'(if_c2.hit_cnt), 32'h0);
    chk({tag, ".c2.sat"}, 32'(if_c2.cnt_sat), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    //             en din clr hit shreg   cnt  hno cno  c2  sat
    vecs[0]  = mk(1, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 4'b0011, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 1, 4'b1101, 1, 1, 1, 1, 0);
    vecs[4]  = mk(1, 1, 0, 0, 4'b1011, 1, 0, 1, 1, 0);
    vecs[5]  = mk(1, 0, 0, 0, 4'b0110, 1, 0, 1, 1, 0);
    vecs[6]  = mk(1, 1, 0, 1, 4'b1101, 2, 0, 1, 2, 0);
    vecs[7]  = mk(1, 1, 0, 0, 4'b1011, 2, 0, 1, 2, 0);
    vecs[8]  = mk(1, 1, 0, 0, 4'b0111, 2, 0, 1, 2, 0);
    vecs[9]  = mk(0, 0, 0, 0, 4'b0111, 2, 0, 1, 2, 0);
    vecs[10] = mk(0, 0, 0, 0, 4'b0111, 2, 0, 1, 2, 0);
    vecs[11] = mk(0, 0, 0, 0, 4'b0111, 2, 0, 1, 2, 0);
    vecs[12] = mk(1, 0, 0, 0, 4'b1110, 2, 0, 1, 2, 0);
    vecs[13] = mk(1, 1, 0, 1, 4'b1101, 3, 1, 2, 3, 1);
    vecs[14] = mk(1, 1, 0, 0, 4'b1011, 3, 0, 2, 3, 1);
    vecs[15] = mk(1, 1, 0, 0, 4'b0111, 3, 0, 2, 3, 1);
    vecs[16] = mk(1, 0, 0, 0, 4'b1110, 3, 0, 2, 3, 1);
    vecs[17] = mk(1, 1, 0, 1, 4'b1101, 4, 1, 3, 3, 1);
    vecs[18] = mk(0, 0, 1, 0, 4'b1101, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, 4'b1011, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 1, 0, 0, 4'b0111, 0, 0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 4'b1110, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 1, 1, 1, 4'b1101, 0, 1, 0, 0, 0);
    vecs[23] = mk(1, 1, 0, 0, 4'b1011, 0, 0, 0, 0, 0);

    #12;
    chk_zero("reset");
    @(negedge cp);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].en, vecs[i].din, vecs[i].clr);
      cyc();
      chk($sformatf("vec%0d.ov.hit", i), 32'(if_ov.hit), 32'(vecs[i].hit));
      chk($sformatf("vec%0d.ov.shreg", i), 32'(if_ov.shreg), 32'(vecs[i].shreg));
      chk($sformatf("vec%0d.ov.cnt", i), 32'(if_ov.hit_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.no.hit", i), 32'(if_no.hit), 32'(vecs[i].hit_no));
      chk($sformatf("vec%0d.no.cnt", i), 32'(if_no.hit_cnt), 32'(vecs[i].cnt_no));
      chk($sformatf("vec%0d.c2.cnt", i), 32'(if_c2.hit_cnt), 32'(vecs[i].cnt_c2));
      chk($sformatf("vec%0d.c2.sat", i), 32'(if_c2.cnt_sat), 32'(vecs[i].sat_c2));
    end

    // Partial pattern 1,1,0 then an asynchronous reset between edges.
    drive(1, 1, 0); cyc();
    drive(1, 1, 0); cyc();
    drive(1, 0, 0); cyc();
    chk("pre_rst.ov.shreg", 32'(if_ov.shreg), 32'hE);
    #2 rst = 1'b1;
    #1;
    chk_zero("async_rst");
    #1 rst = 1'b0;

    drive(1, 1, 0); cyc();
    chk("post_rst1.ov.hit", 32'(if_ov.hit), 32'h0);
    chk("post_rst1.ov.shreg", 32'(if_ov.shreg), 32'h1);
    chk("post_rst1.no.hit", 32'(if_no.hit), 32'h0);
    drive(1, 1, 0); cyc();
    drive(1, 0, 0); cyc();
    chk("post_rst3.ov.hit", 32'(if_ov.hit), 32'h0);
    drive(1, 1, 0); cyc();
    chk("post_rst4.ov.hit", 32'(if_ov.hit), 32'h1);
    chk("post_rst4.ov.cnt", 32'(if_ov.hit_cnt), 32'h1);
    chk("post_rst4.no.hit", 32'(if_no.hit), 32'h1);
    chk("post_rst4.c2.cnt", 32'(if_c2.hit_cnt), 32'h1);
    drive(0, 1, 0); cyc();
    chk("en_low.ov.hit", 32'(if_ov.hit), 32'h0);
    chk("en_low.ov.shreg", 32'(if_ov.shreg), 32'hD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
